// File: rtl/bsg_link_pkg.sv
// rtl/bsg_link_pkg.sv - shared link geometry and beat-step type
package bsg_link_pkg;

    localparam int CHANNEL_WIDTH  = 8;
    localparam int NUM_CHANNELS   = 2;
    localparam int BEATS_PER_WORD = 4;
    localparam int WORD_WIDTH     = 64;
    localparam int CREDIT_MAX     = 64;

    typedef logic [1:0] step_t;

    localparam step_t LAST_STEP = step_t'(BEATS_PER_WORD - 1);

endpackage

// File: rtl/bsg_downstream_fifo.sv
// rtl/bsg_downstream_fifo.sv - receive word buffer with occupancy count
module bsg_downstream_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_v,
    input  logic [WIDTH-1:0]         enq_data,
    input  logic                     deq_yumi,
    output logic                     deq_v,
    output logic [WIDTH-1:0]         deq_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             enq;
    logic             deq;

    assign deq_v    = (count != '0);
    assign deq_data = mem[rptr];
    assign deq      = deq_yumi && deq_v;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign enq      = enq_v && ((count != FULL_COUNT) || deq);

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wptr] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bsg_downstream_in.sv
// rtl/bsg_downstream_in.sv - link beat assembler, credit return and receive buffer
module bsg_downstream_in
    import bsg_link_pkg::*;
#(
    parameter int DEPTH = CREDIT_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_valid_in,
    input  logic [CHANNEL_WIDTH-1:0] io_data_in_ch0,
    input  logic [CHANNEL_WIDTH-1:0] io_data_in_ch1,
    output logic                     io_token_out,
    output logic                     core_valid_out,
    output logic [WORD_WIDTH-1:0]    core_data_out,
    input  logic                     core_yumi_in,
    output logic                     overflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    step_t                 step;
    logic [WORD_WIDTH-1:0] partial;
    logic [WORD_WIDTH-1:0] assembled;
    logic [5:0]            ch0_base;
    logic [5:0]            ch1_base;
    logic [CW-1:0]         count;
    logic                  word_done;
    logic                  deq;
    logic                  enq_ok;

    // Step bit 1 picks the 32-bit half, bit 0 the byte within each 16-bit lane.
    assign ch0_base = {step[1], 1'b0, step[0], 3'b000};
    assign ch1_base = {step[1], 1'b1, step[0], 3'b000};

    always_comb begin
        assembled = partial;
        assembled[ch0_base +: CHANNEL_WIDTH] = io_data_in_ch0;
        assembled[ch1_base +: CHANNEL_WIDTH] = io_data_in_ch1;
    end

    assign word_done = io_valid_in && (step == LAST_STEP);
    assign deq       = core_yumi_in && core_valid_out;
    assign enq_ok    = word_done && ((count != FULL_COUNT) || deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            step         <= '0;
            partial      <= '0;
            overflow_o   <= 1'b0;
            io_token_out <= 1'b0;
        end else begin
            io_token_out <= deq;
            if (io_valid_in) begin
                step    <= step + 1'b1;
                partial <= assembled;
            end
            if (word_done && !enq_ok) begin
                overflow_o <= 1'b1;
            end
        end
    end

    bsg_downstream_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq_v    (enq_ok),
        .enq_data (assembled),
        .deq_yumi (core_yumi_in),
        .deq_v    (core_valid_out),
        .deq_data (core_data_out),
        .count    (count)
    );

endmodule

// File: tb/tb_bsg_downstream_in.sv
// tb/tb_bsg_downstream_in.sv - scoreboard bench for bsg_downstream_in
module tb_bsg_downstream_in;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_valid_in;
    logic [7:0]  io_data_in_ch0;
    logic [7:0]  io_data_in_ch1;
    logic        io_token_out;
    logic        core_valid_out;
    logic [63:0] core_data_out;
    logic        core_yumi_in;
    logic        overflow_o;

    bsg_downstream_in #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .io_valid_in    (io_valid_in),
        .io_data_in_ch0 (io_data_in_ch0),
        .io_data_in_ch1 (io_data_in_ch1),
        .io_token_out   (io_token_out),
        .core_valid_out (core_valid_out),
        .core_data_out  (core_data_out),
        .core_yumi_in   (core_yumi_in),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tokens = 0;

    logic [63:0] sb[$];
    logic [63:0] mword;
    int          mstep;
    logic        mover;

    // Byte index of ch0 / ch1 inside the 64-bit word for steps 0..3.
    int idx0[4] = '{0, 1, 4, 5};
    int idx1[4] = '{2, 3, 6, 7};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check pre-edge outputs, update model, check post-edge.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic y);
        logic deq;
        logic acc;
        io_valid_in    = v;
        io_data_in_ch0 = a;
        io_data_in_ch1 = b;
        core_yumi_in   = y;
        chk("valid", {63'd0, core_valid_out}, {63'd0, sb.size() != 0});
        if (sb.size() != 0) chk("head", core_data_out, sb[0]);
        deq = y && (sb.size() != 0);
        acc = (sb.size() < DEPTH) || deq;
        if (deq) void'(sb.pop_front());
        if (v) begin
            mword[idx0[mstep]*8 +: 8] = a;
            mword[idx1[mstep]*8 +: 8] = b;
            if (mstep == 3) begin
                if (acc) sb.push_back(mword);
                else mover = 1'b1;
            end
            mstep = (mstep + 1) % 4;
        end
        @(negedge clk);
        chk("token", {63'd0, io_token_out}, {63'd0, deq});
        chk("overflow", {63'd0, overflow_o}, {63'd0, mover});
        if (io_token_out) tokens++;
    endtask

    task automatic send_word(input logic [63:0] w, input logic y, input logic y_last);
        for (int s = 0; s < 4; s++)
            cycle(1'b1, w[idx0[s]*8 +: 8], w[idx1[s]*8 +: 8], (s == 3) ? y_last : y);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        io_valid_in    = 1'b1;
        io_data_in_ch0 = 8'hAA;
        io_data_in_ch1 = 8'hBB;
        core_yumi_in   = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        io_valid_in  = 1'b0;
        core_yumi_in = 1'b0;
        sb.delete();
        mword = '0;
        mstep = 0;
        mover = 1'b0;
        chk("rst_valid", {63'd0, core_valid_out}, 64'd0);
        chk("rst_token", {63'd0, io_token_out}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_o}, 64'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        io_valid_in = 1'b0;
        io_data_in_ch0 = '0;
        io_data_in_ch1 = '0;
        core_yumi_in = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic word from consecutive beats.
        cycle(1'b1, 8'h11, 8'h33, 1'b0);
        cycle(1'b1, 8'h22, 8'h44, 1'b0);
        cycle(1'b1, 8'h55, 8'h77, 1'b0);
        cycle(1'b1, 8'h66, 8'h88, 1'b0);
        chk("basic_word", core_data_out, 64'h8877665544332211);
        chk("basic_valid", {63'd0, core_valid_out}, 64'd1);
        drain(2);

        // Same beats with idle gaps.
        cycle(1'b1, 8'h11, 8'h33, 1'b0);
        cycle(1'b0, 8'hFF, 8'hFF, 1'b0);
        cycle(1'b1, 8'h22, 8'h44, 1'b0);
        cycle(1'b0, 8'hFF, 8'hFF, 1'b0);
        cycle(1'b0, 8'hFF, 8'hFF, 1'b0);
        cycle(1'b1, 8'h55, 8'h77, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'hEE, 8'hEE, 1'b0);
        cycle(1'b1, 8'h66, 8'h88, 1'b0);
        chk("gap_word", core_data_out, 64'h8877665544332211);
        drain(2);

        // Fill to capacity, then overflow.
        for (int i = 0; i < DEPTH; i++) send_word({$urandom, $urandom}, 1'b0, 1'b0);
        chk("full_count", 64'(sb.size()), 64'd64);
        chk("full_no_ovf", {63'd0, overflow_o}, 64'd0);
        send_word(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
        chk("ovf_set", {63'd0, overflow_o}, 64'd1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0);

        // Full buffer with yumi on the final beat: accepted.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_word({$urandom, $urandom}, 1'b0, 1'b0);
        send_word(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        chk("simul_count", 64'(sb.size()), 64'd64);
        chk("simul_tail", sb[DEPTH-1], 64'h0123_4567_89AB_CDEF);
        chk("simul_no_ovf", {63'd0, overflow_o}, 64'd0);
        drain(DEPTH + 2);

        // Ten words with yumi held; yumi while empty gives no token.
        do_reset();
        tokens = 0;
        for (int i = 0; i < 10; i++) send_word({$urandom, $urandom}, 1'b1, 1'b1);
        drain(4);
        chk("token_count", 64'(tokens), 64'd10);

        // Reset mid-word discards partial beats.
        cycle(1'b1, 8'hA1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 8'hA4, 1'b0);
        do_reset();
        send_word(64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);
        chk("rst_mid_word", core_data_out, 64'hCAFE_F00D_1234_5678);
        drain(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
